// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the memory-mapped UART controller:
// register offsets, UART_CON bit positions and the TX sequencer states.
package uart_ctrl_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [31:0] TXD_OFF = 32'h0000_0000;
  localparam logic [31:0] RXD_OFF = 32'h0000_0004;
  localparam logic [31:0] CON_OFF = 32'h0000_0008;

  // UART_CON bit positions
  localparam int CON_TX_IE     = 0;
  localparam int CON_RX_IE     = 1;
  localparam int CON_RX_VALID  = 2;
  localparam int CON_TX_DONE   = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_OVERRUN   = 5;
  localparam int CON_FIFO_FULL = 6;
  localparam int CON_DROP      = 7;

  // TX sequencer: one frame at a time, launch pulse then wait for idle
  typedef enum logic [1:0] {
    TX_IDLE   = 2'b00,
    TX_LAUNCH = 2'b01,
    TX_BUSY   = 2'b10
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding CPU-written bytes until the transmitter
// is free. Pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate counter.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags from the pre-edge pointers; a push while full is dropped
  // even if a pop happens in the same cycle.
  always_comb begin
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    empty     = (wr_ptr_r == rd_ptr_r);
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    head      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer advance, wrapping modulo 2*DEPTH
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since empty masks them
  always_ff @(posedge sysclk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: address decode, RX holding register with
// overrun tracking, TX FIFO plus launch sequencer, and interrupt request.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  output logic        sel,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        tx_status,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        irq
);

  tx_state_e   state_r;
  tx_state_e   state_nx_s;

  logic        hit_txd_s, hit_rxd_s, hit_con_s;
  logic        rd_rxd_s, rd_con_s, wr_txd_s, wr_con_s;
  logic        pop_s, tx_end_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_head_s;
  logic [7:0]  con_s;
  logic        overrun_set_s, drop_set_s;

  logic        tx_ie_r, rx_ie_r, rx_valid_r, tx_done_r, overrun_r, drop_r;
  logic [7:0]  rx_byte_r;
  logic        tx_start_r, irq_r;
  logic [7:0]  tx_data_r;

  // Only the low byte of write data carries meaning
  logic        unused_wdata_s;
  assign unused_wdata_s = ^wdata[31:8];

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (wr_txd_s),
    .pop    (pop_s),
    .wdata  (wdata[7:0]),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .head   (fifo_head_s)
  );

  // Address decode and bus strobes qualified by register hit
  always_comb begin
    hit_txd_s     = (addr == (BASE_ADDR + TXD_OFF));
    hit_rxd_s     = (addr == (BASE_ADDR + RXD_OFF));
    hit_con_s     = (addr == (BASE_ADDR + CON_OFF));
    rd_rxd_s      = MemRead  & hit_rxd_s;
    rd_con_s      = MemRead  & hit_con_s;
    wr_txd_s      = MemWrite & hit_txd_s;
    wr_con_s      = MemWrite & hit_con_s;
    overrun_set_s = rx_done & rx_valid_r & ~rd_rxd_s;
    drop_set_s    = wr_txd_s & fifo_full_s;
  end

  // UART_CON image assembled from the live status bits
  always_comb begin
    con_s                = 8'h00;
    con_s[CON_TX_IE]     = tx_ie_r;
    con_s[CON_RX_IE]     = rx_ie_r;
    con_s[CON_RX_VALID]  = rx_valid_r;
    con_s[CON_TX_DONE]   = tx_done_r;
    con_s[CON_TX_BUSY]   = (state_r != TX_IDLE) | ~fifo_empty_s;
    con_s[CON_OVERRUN]   = overrun_r;
    con_s[CON_FIFO_FULL] = fifo_full_s;
    con_s[CON_DROP]      = drop_r;
  end

  // Combinational read mux; TXD and unmapped addresses read as zero
  always_comb begin
    sel = hit_txd_s | hit_rxd_s | hit_con_s;
    if (hit_rxd_s) begin
      rdata = {24'h00_0000, rx_byte_r};
    end else if (hit_con_s) begin
      rdata = {24'h00_0000, con_s};
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // TX sequencer next state: pop on launch, flag completion on return to idle
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    tx_end_s   = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (!fifo_empty_s && tx_status) begin
          state_nx_s = TX_LAUNCH;
          pop_s      = 1'b1;
        end else begin
          state_nx_s = TX_IDLE;
        end
      end
      TX_LAUNCH: begin
        if (!tx_status) begin
          state_nx_s = TX_BUSY;
        end else begin
          state_nx_s = TX_LAUNCH;
        end
      end
      TX_BUSY: begin
        if (tx_status) begin
          state_nx_s = TX_IDLE;
          tx_end_s   = 1'b1;
        end else begin
          state_nx_s = TX_BUSY;
        end
      end
      default: begin
        state_nx_s = TX_IDLE;
      end
    endcase
  end

  // TX sequencer state register
  always_ff @(posedge sysclk) begin
    if (reset) state_r <= TX_IDLE;
    else       state_r <= state_nx_s;
  end

  // Launch pulse and byte latch toward the transmitter
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      tx_start_r <= pop_s;
      if (pop_s) tx_data_r <= fifo_head_s;
    end
  end

  // RX holding register; a coincident RXD read keeps valid set without overrun
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else if (rx_done) begin
      rx_byte_r  <= rx_data;
      rx_valid_r <= 1'b1;
    end else if (rd_rxd_s) begin
      rx_valid_r <= 1'b0;
    end
  end

  // CON enables and sticky flags; a set beats a simultaneous CON-read clear
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_ie_r   <= 1'b0;
      rx_ie_r   <= 1'b0;
      tx_done_r <= 1'b0;
      overrun_r <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      if (wr_con_s) begin
        tx_ie_r <= wdata[CON_TX_IE];
        rx_ie_r <= wdata[CON_RX_IE];
      end
      tx_done_r <= tx_end_s      | (tx_done_r & ~rd_con_s);
      overrun_r <= overrun_set_s | (overrun_r & ~rd_con_s);
      drop_r    <= drop_set_s    | (drop_r    & ~rd_con_s);
    end
  end

  // Interrupt request, one cycle behind its sources
  always_ff @(posedge sysclk) begin
    if (reset) irq_r <= 1'b0;
    else       irq_r <= (rx_ie_r & rx_valid_r) | (tx_ie_r & tx_done_r);
  end

  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;
  assign irq      = irq_r;

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped UART controller between the single-cycle CPU's data bus and the existing UART receiver/transmitter pair, both clocked from the baud-rate/sample-clock path. It captures received bytes in a holding register with status and overrun tracking. It queues CPU-written bytes in a small TX FIFO and sequences the transmitter one frame at a time. It raises an interrupt request on RX-valid or TX-done.

## Interface
Parameters:
- `BASE_ADDR`, 32'h4000_0018: address of UART_TXD; UART_RXD at +4, UART_CON at +8.
- `TX_DEPTH`, 4: TX FIFO entries; power of two, ≥2.

Ports:
- `sysclk` in 1: system clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `addr` in 32: CPU data address.
- `wdata` in 32: CPU write data; only [7:0] used.
- `MemRead` in 1: read strobe, valid for one cycle.
- `MemWrite` in 1: write strobe, valid for one cycle.
- `rdata` out 32: read data, combinational from `addr`; zero when not selected.
- `sel` out 1: `addr` hits one of the three registers.
- `rx_done` in 1: one-cycle pulse from the receiver, byte complete.
- `rx_data` in 8: received byte, valid with `rx_done`.
- `tx_status` in 1: transmitter idle (1) / busy (0).
- `tx_start` out 1: one-cycle launch pulse to the transmitter.
- `tx_data` out 8: byte to send; held stable from `tx_start` until `tx_status` falls.
- `irq` out 1: registered interrupt request.

## Operation
- UART_TXD write: push `wdata[7:0]` into the FIFO. If the FIFO is full (pre-edge count), drop the byte and set `drop`. A same-cycle pop does not rescue it. Reads return 0.
- UART_RXD read: returns {24'b0, rx_byte} and clears `rx_valid` at the edge.
- UART_CON bits:
  - [0] `tx_ie` RW
  - [1] `rx_ie` RW
  - [2] `rx_valid` RO
  - [3] `tx_done` sticky
  - [4] `tx_busy` RO, FSM≠IDLE or FIFO non-empty
  - [5] `overrun` sticky
  - [6] `fifo_full` RO
  - [7] `drop` sticky
  - Sticky bits [3], [5], [7] clear on a CON read.
  - Writes update only [1:0].
- RX path:
  - `rx_done` loads `rx_byte` and sets `rx_valid`.
  - If `rx_valid` was already 1 and no RXD read occurs that cycle, the new byte overwrites and `overrun` is set.
  - `rx_done` coincident with an RXD read: the new byte loads, `rx_valid` stays 1, no overrun.
- TX FSM, states IDLE, LAUNCH, BUSY:
  - IDLE → LAUNCH when FIFO non-empty and `tx_status`=1. On that edge, pop the head into the `tx_data` register and pulse `tx_start` for exactly one cycle.
  - LAUNCH → BUSY when `tx_status`=0.
  - BUSY → IDLE when `tx_status`=1. On that edge, set `tx_done`.
- A sticky set and a CON read on the same edge: the set wins.
- `irq` = registered (`rx_ie`&`rx_valid`) | (`tx_ie`&`tx_done`).

## Timing
- Reset values:
  - `tx_start`, `irq`, `tx_data`: 0.
  - FIFO empty, pointers 0, FSM IDLE.
  - All CON bits 0; `rx_byte` 0.
- Reset mid-frame: the FSM returns to IDLE and queued bytes are discarded. The transmitter finishes its frame independently. The next launch still waits for `tx_status`=1.
- `rdata` has zero-cycle latency (combinational). Side-effecting clears apply at the edge ending the read cycle.
- TXD write to `tx_start`:
  - Empty FIFO, idle transmitter: `tx_start` asserts the cycle after the write edge (1-cycle latency).
  - Otherwise it waits for BUSY→IDLE plus 1 cycle.
- Back-to-back frames are separated by at least one IDLE cycle.
- `irq` follows its sources with one cycle of delay.
- FIFO pointers are log2(`TX_DEPTH`)+1 bits and wrap modulo 2·`TX_DEPTH`.
  - Full: MSBs differ and the rest are equal.
  - Empty: pointers equal.

## Structure
- `uart_ctrl_pkg`:
  - register offsets;
  - CON bit-position localparams;
  - TX FSM state encoding (2-bit).
- Sub-module `uart_tx_fifo` (parameterised depth, width 8, push/pop/full/empty/head).
- Top level contains the address decode, RX holding logic, CON register, TX FSM and irq register.

## Test plan
- RX of 8'h24 with `rx_ie`=1 → `rx_valid`=1 and `irq`=1 one cycle later. RXD read returns 32'h24, then `rx_valid`=0 and `irq`=0.
- RX 8'h24 then 8'h30 with no read → RXD=32'h30, CON[5]=1. A CON read clears bit 5. A second `rx_done` in the same cycle as an RXD read sets no overrun.
- Write 8'h0C to TXD with `tx_status`=1 → `tx_start` high for exactly 1 cycle with `tx_data`=8'h0C. Model: `tx_status` low for 100 cycles → CON[3]=1 on return high; with `tx_ie`=1, `irq` rises.
- Five consecutive TXD writes (8'h01–8'h05) with `TX_DEPTH`=4 while busy → 8'h05 dropped, CON[7]=1, CON[6]=1. Bytes 01–04 transmitted in order, then CON[4]=0.
- Queue three bytes, assert `reset` for 1 cycle during the first frame → all outputs and CON at reset values. No further `tx_start` until a new write.
